dct_1d_pipe: RTL

Parametrised, fully pipelined 8-point 1-D DCT-II / inverse DCT (DCT-III) engine with valid/ready flow control and frame sideband propagation. It replaces the fixed-latency, non-stallable 1-D DCT stage in the JPEG encode path and is also used on the decode path. One stage sits on each of the row and column passes around the transpose buffer. Per-beat mode select lets one instance serve both directions.

---
 rtl/dct_1d_pipe.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/dct_1d_pipe.sv
// dct_1d_pipe: 8-point 1-D DCT-II (forward) / DCT-III (inverse) engine.
// Four register stages that advance together and freeze together on output backpressure.
module dct_1d_pipe #(
  parameter int unsigned W_I = 16,
  parameter int unsigned W_O = 16,
  parameter int unsigned W_C = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8*W_I-1:0] in_data,
  input  logic             in_inv,
  input  logic             in_sob,
  input  logic             in_eob,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8*W_O-1:0] out_data,
  output logic             out_sat,
  output logic             out_sob,
  output logic             out_eob,
  output logic             out_sof
);

  localparam int unsigned N     = 8;
  localparam int unsigned W_P   = W_I + W_C;      // single product
  localparam int unsigned W_PS  = W_P + 2;        // sum of four products
  localparam int unsigned W_ACC = W_I + W_C + 3;  // full-precision lane sum
  localparam int unsigned SHR   = W_C - 1;
  localparam int unsigned W_R   = W_ACC - SHR;    // lane value after scaling down

  localparam logic signed [W_ACC-1:0] RND  = W_ACC'(2 ** (W_C - 2));
  localparam logic signed [W_R-1:0]   MAXV = {{(W_R - W_O + 1){1'b0}}, {(W_O - 1){1'b1}}};
  localparam logic signed [W_R-1:0]   MINV = {{(W_R - W_O + 1){1'b1}}, {(W_O - 1){1'b0}}};

  // Control travelling alongside each beat.
  typedef struct packed {
    logic valid;
    logic inv;
    logic sob;
    logic eob;
    logic sof;
  } ctrl_t;

  typedef logic [N*N-1:0][W_C-1:0] coef_tbl_t;

  // cos(m*pi/16) for m = 0..8.
  function automatic real cos_pi16(input int unsigned m);
    case (m)
      0:       return 1.0;
      1:       return 0.9807852804032304;
      2:       return 0.9238795325112867;
      3:       return 0.8314696123025452;
      4:       return 0.7071067811865476;
      5:       return 0.5555702330196022;
      6:       return 0.3826834323650898;
      7:       return 0.1950903220161283;
      default: return 0.0;
    endcase
  endfunction

  // C[k][n] = round(2^(W_C-1) * c(k) * cos((2n+1)k*pi/16)), stored at index k*8+n.
  function automatic coef_tbl_t gen_coef();
    coef_tbl_t   tbl;
    real         r;
    real         scale;
    int unsigned m;
    int          v;
    tbl   = '0;
    scale = 1.0;
    for (int unsigned i = 0; i < W_C - 1; i++) scale = scale * 2.0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned n = 0; n < N; n++) begin
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        r = (m > 8) ? -cos_pi16(16 - m) : cos_pi16(m);
        r = r * scale * ((k == 0) ? 0.3535533905932738 : 0.5);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        tbl[k*N+n] = W_C'(v);
      end
    end
    return tbl;
  endfunction

  localparam coef_tbl_t COEF = gen_coef();

  ctrl_t                    c1_d, c1_q, c2_q, c3_q, c4_q;
  logic signed [W_I-1:0]    x1_d  [N];
  logic signed [W_I-1:0]    x1_q  [N];
  logic signed [W_P-1:0]    p2_d  [N*N];
  logic signed [W_P-1:0]    p2_q  [N*N];
  logic signed [W_PS-1:0]   ps3_d [2*N];
  logic signed [W_PS-1:0]   ps3_q [2*N];
  logic [8*W_O-1:0]         data4_d, data4_q;
  logic                     sat4_d, sat4_q;
  logic signed [W_ACC-1:0]  acc4;
  logic signed [W_R-1:0]    rnd4;
  logic                     stall;
  logic                     adv;
  logic                     unused_inv4;

  // Whole-pipe freeze while the output beat is waiting on the consumer.
  assign stall    = c4_q.valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // S1 inputs: unpack lanes and bundle sideband.
  always_comb begin
    c1_d = ctrl_t'{valid: in_valid, inv: in_inv, sob: in_sob, eob: in_eob, sof: in_sof};
    for (int i = 0; i < N; i++) x1_d[i] = in_data[i*W_I +: W_I];
  end

  // S2 inputs: output lane j, term m uses C[j][m] forward or C[m][j] inverse.
  for (genvar j = 0; j < N; j++) begin : g_lane
    for (genvar m = 0; m < N; m++) begin : g_term
      localparam logic signed [W_C-1:0] CF = COEF[j*N+m];
      localparam logic signed [W_C-1:0] CI = COEF[m*N+j];
      assign p2_d[j*N+m] = W_P'(c1_q.inv ? CI : CF) * W_P'(x1_q[m]);
    end
    // S3 inputs: per lane, one partial sum over terms 0..3 and one over 4..7.
    for (genvar h = 0; h < 2; h++) begin : g_half
      assign ps3_d[j*2+h] = W_PS'(p2_q[j*N+h*4])     + W_PS'(p2_q[j*N+h*4+1])
                          + W_PS'(p2_q[j*N+h*4+2])   + W_PS'(p2_q[j*N+h*4+3]);
    end
  end

  // S4 inputs: final sum, round half up, saturate each lane and flag clipping.
  always_comb begin
    data4_d = '0;
    sat4_d  = 1'b0;
    acc4    = '0;
    rnd4    = '0;
    for (int j = 0; j < N; j++) begin
      acc4 = W_ACC'(ps3_q[2*j]) + W_ACC'(ps3_q[2*j+1]) + RND;
      rnd4 = W_R'(acc4 >>> SHR);
      if (rnd4 > MAXV) begin
        data4_d[j*W_O +: W_O] = MAXV[W_O-1:0];
        sat4_d = 1'b1;
      end else if (rnd4 < MINV) begin
        data4_d[j*W_O +: W_O] = MINV[W_O-1:0];
        sat4_d = 1'b1;
      end else begin
        data4_d[j*W_O +: W_O] = rnd4[W_O-1:0];
      end
    end
  end

  // S1: input capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q <= '0;
      x1_q <= '{default: '0};
    end else if (adv) begin
      c1_q <= c1_d;
      x1_q <= x1_d;
    end
  end

  // S2: mode-selected constant products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c2_q <= '0;
      p2_q <= '{default: '0};
    end else if (adv) begin
      c2_q <= c1_q;
      p2_q <= p2_d;
    end
  end

  // S3: partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c3_q  <= '0;
      ps3_q <= '{default: '0};
    end else if (adv) begin
      c3_q  <= c2_q;
      ps3_q <= ps3_d;
    end
  end

  // S4: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c4_q    <= '0;
      data4_q <= '0;
      sat4_q  <= 1'b0;
    end else if (adv) begin
      c4_q    <= c3_q;
      data4_q <= data4_d;
      sat4_q  <= sat4_d;
    end
  end

  assign out_valid = c4_q.valid;
  assign out_sob   = c4_q.sob;
  assign out_eob   = c4_q.eob;
  assign out_sof   = c4_q.sof;
  assign out_data  = data4_q;
  assign out_sat   = sat4_q;

  // The mode bit has no consumer once the products are formed; it rides along for debug.
  assign unused_inv4 = c4_q.inv;

endmodule
